// File: rtl/clock_divider_ctrl.sv
// Half-integer clock divider with a valid/ready ratio interface; new ratios and
// stop requests take effect only at a super-period (two output periods) boundary.
module clock_divider_ctrl #(
  parameter int TCQ          = 1,
  parameter int C_DIV2_W     = 8,
  parameter int C_DIV2_INIT  = 9,
  parameter bit C_AUTO_START = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                en_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [C_DIV2_W-1:0] cfg_div2_i,
  output logic                cfg_err_o,
  output logic                upd_o,
  output logic [C_DIV2_W-1:0] div2_act_o,
  output logic                running_o,
  output logic                clk_div_o
);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  localparam logic [C_DIV2_W-1:0] DIV2_INIT = C_DIV2_W'(C_DIV2_INIT);
  localparam logic [C_DIV2_W-1:0] DIV2_MIN  = C_DIV2_W'(4);
  localparam logic [C_DIV2_W-1:0] ONE       = C_DIV2_W'(1);

  if (C_DIV2_INIT < 4 || TCQ < 0) begin : g_param_check
    $error("clock_divider_ctrl: C_DIV2_INIT must be at least 4");
  end

  logic [1:0]          state;
  logic [C_DIV2_W-1:0] cnt;
  logic [C_DIV2_W-1:0] div2_act;
  logic [C_DIV2_W-1:0] pend_div2;
  logic [C_DIV2_W-1:0] half;
  logic [C_DIV2_W-1:0] half_odd;
  logic                en_q;
  logic                pos_q;
  logic                neg_q;
  logic                active;
  logic                wrap;
  logic                accept;
  logic                cfg_legal;
  logic                pos_hit;
  logic                neg_hit;

  assign active    = (state == ST_RUN) || (state == ST_PEND);
  assign wrap      = active && (cnt == div2_act - ONE);
  assign cfg_ready_o = (state != ST_PEND);
  assign accept    = cfg_valid_i && cfg_ready_o;
  assign cfg_legal = (cfg_div2_i >= DIV2_MIN);
  assign half      = div2_act >> 1;
  assign half_odd  = half + ONE;

  // Odd ratios put the second pulse on a falling edge so both periods are equal.
  assign pos_hit = active && ((cnt == '0) || (!div2_act[0] && (cnt == half)));
  assign neg_hit = active && div2_act[0] && (cnt == half_odd);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= C_AUTO_START ? ST_RUN : ST_OFF;
      en_q      <= C_AUTO_START;
      cnt       <= '0;
      div2_act  <= DIV2_INIT;
      pend_div2 <= DIV2_INIT;
      pos_q     <= 1'b0;
      cfg_err_o <= 1'b0;
      upd_o     <= 1'b0;
    end else begin
      en_q      <= en_i;
      pos_q     <= pos_hit;
      cfg_err_o <= accept && !cfg_legal;
      upd_o     <= 1'b0;
      case (state)
        ST_OFF: begin
          cnt <= '0;
          if (accept && cfg_legal) begin
            div2_act <= cfg_div2_i;
            upd_o    <= 1'b1;
          end
          if (en_q) state <= ST_RUN;
        end
        ST_RUN: begin
          cnt <= wrap ? '0 : cnt + ONE;
          // A ratio arriving on the stopping wrap is applied directly, as it would be in OFF.
          if (wrap && !en_q) begin
            state <= ST_OFF;
            if (accept && cfg_legal) begin
              div2_act <= cfg_div2_i;
              upd_o    <= 1'b1;
            end
          end else if (accept && cfg_legal) begin
            pend_div2 <= cfg_div2_i;
            state     <= ST_PEND;
          end
        end
        ST_PEND: begin
          cnt <= wrap ? '0 : cnt + ONE;
          if (wrap) begin
            div2_act <= pend_div2;
            upd_o    <= 1'b1;
            state    <= en_q ? ST_RUN : ST_OFF;
          end
        end
        default: begin
          state <= ST_OFF;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) neg_q <= 1'b0;
    else          neg_q <= neg_hit;
  end

  assign clk_div_o  = pos_q | neg_q;
  assign div2_act_o = div2_act;
  assign running_o  = active;

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Randomized and directed bench for clock_divider_ctrl, checked against a model that
// predicts the output from pulse windows measured in half clock periods.
module tb_clock_divider_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         cfg_valid;
  logic [W-1:0] cfg_div2;
  logic         cfg_ready_o;
  logic         cfg_err_o;
  logic         upd_o;
  logic [W-1:0] div2_act_o;
  logic         running_o;
  logic         clk_div_o;

  int errors = 0;
  int checks = 0;

  clock_divider_ctrl dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .en_i        (en),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready_o),
    .cfg_div2_i  (cfg_div2),
    .cfg_err_o   (cfg_err_o),
    .upd_o       (upd_o),
    .div2_act_o  (div2_act_o),
    .running_o   (running_o),
    .clk_div_o   (clk_div_o)
  );

  always #5 clk = ~clk;

  longint last_rise = -1;
  longint prev_rise = -1;
  longint last_pos_t = 0;

  always @(posedge clk_div_o) begin
    prev_rise = last_rise;
    last_rise = $time;
  end

  // Reference: a running super-period of div2 half-cycle units starts at posedge m_start;
  // the output is high in half-cycle windows [2,4) and [div2+2,div2+4) of it.
  bit m_on, m_pend_valid, m_en_d, m_err, m_upd;
  int m_start, m_n, m_div2, m_pend;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic bit windowHigh(input int p, input int d2);
    return ((p >= 2) && (p < 4)) || ((p >= d2 + 2) && (p < d2 + 4));
  endfunction

  function automatic bit expClk(input int half_step);
    return m_on && windowHigh(2 * (m_n - m_start) + half_step, m_div2);
  endfunction

  task automatic modelReset();
    m_on = 0; m_pend_valid = 0; m_en_d = 0; m_err = 0; m_upd = 0;
    m_div2 = 9; m_pend = 9; m_start = 0; m_n = 0;
  endtask

  task automatic modelEdge(input bit e, input bit v, input int d);
    bit accept, legal, wrap;
    m_n++;
    accept = v && !m_pend_valid;
    legal  = (d >= 4);
    m_err  = accept && !legal;
    m_upd  = 0;
    wrap   = m_on && (m_n - m_start == m_div2);
    if (!m_on) begin
      if (accept && legal) begin m_div2 = d; m_upd = 1; end
      if (m_en_d) begin m_on = 1; m_start = m_n; end
    end else if (wrap) begin
      m_start = m_n;
      if (m_pend_valid) begin
        m_div2 = m_pend; m_pend_valid = 0; m_upd = 1; m_on = m_en_d;
      end else if (!m_en_d) begin
        m_on = 0;
        if (accept && legal) begin m_div2 = d; m_upd = 1; end
      end else if (accept && legal) begin
        m_pend = d; m_pend_valid = 1;
      end
    end else if (accept && legal) begin
      m_pend = d; m_pend_valid = 1;
    end
    m_en_d = e;
  endtask

  task automatic applyStimulus(input bit e, input bit v, input int d);
    en = e; cfg_valid = v; cfg_div2 = W'(d);
    @(posedge clk);
    last_pos_t = $time;
    modelEdge(e, v, d);
    #1;
    checkOutput("clk_div_pos", clk_div_o, expClk(0));
    checkOutput("running", running_o, m_on);
    checkOutput("cfg_ready", cfg_ready_o, !m_pend_valid);
    checkOutput("cfg_err", cfg_err_o, m_err);
    checkOutput("upd", upd_o, m_upd);
    checkOutput("div2_act", div2_act_o, m_div2);
    @(negedge clk);
    #1;
    checkOutput("clk_div_neg", clk_div_o, expClk(1));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_clk_div"}, clk_div_o, 0);
    checkOutput({tag, "_err"}, cfg_err_o, 0);
    checkOutput({tag, "_upd"}, upd_o, 0);
    checkOutput({tag, "_div2"}, div2_act_o, 9);
    checkOutput({tag, "_running"}, running_o, 0);
    checkOutput({tag, "_ready"}, cfg_ready_o, 1);
  endtask

  initial begin
    bit seen;
    int upd_count;
    longint t0;
    int d;

    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div2 = '0;
    repeat (2) @(negedge clk);
    #1;
    checkResetValues("reset");
    rst_n = 1'b1;
    modelReset();

    // 1: default ratio 9 -> rises 4.5 periods apart
    for (int i = 0; i < 40; i++) applyStimulus(1, 0, 0);
    checkOutput("t1_gap", 32'(last_rise - prev_rise), 45);

    // 2: ratio 6 offered at cnt 3
    for (int i = 0; i < 20 && !(m_on && (m_n - m_start == 3)); i++) applyStimulus(1, 0, 0);
    checkOutput("t2_cnt3_reached", (m_n - m_start == 3), 1);
    applyStimulus(1, 1, 6);
    checkOutput("t2_ready_drop", cfg_ready_o, 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      applyStimulus(1, 0, 0);
      seen = upd_o;
    end
    checkOutput("t2_upd_seen", seen, 1);
    for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0);
    checkOutput("t2_gap", 32'(last_rise - prev_rise), 30);
    checkOutput("t2_div2", div2_act_o, 6);

    // 3: illegal ratio
    applyStimulus(1, 1, 3);
    checkOutput("t3_err", cfg_err_o, 1);
    applyStimulus(1, 0, 0);
    checkOutput("t3_err_once", cfg_err_o, 0);
    for (int i = 0; i < 12; i++) applyStimulus(1, 0, 0);
    checkOutput("t3_gap", 32'(last_rise - prev_rise), 30);
    checkOutput("t3_div2", div2_act_o, 6);

    // 4: ratio 8, stop at cnt 2, then restart
    applyStimulus(1, 1, 8);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      applyStimulus(1, 0, 0);
      seen = upd_o;
    end
    checkOutput("t4_upd_seen", seen, 1);
    for (int i = 0; i < 12; i++) applyStimulus(1, 0, 0);
    checkOutput("t4_gap", 32'(last_rise - prev_rise), 40);
    for (int i = 0; i < 20 && !(m_on && (m_n - m_start == 2)); i++) applyStimulus(1, 0, 0);
    checkOutput("t4_cnt2_reached", (m_n - m_start == 2), 1);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0);
    checkOutput("t4_off", running_o, 0);
    checkOutput("t4_clk_low", clk_div_o, 0);
    applyStimulus(1, 0, 0);
    t0 = last_pos_t;
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0);
    checkOutput("t4_first_rise", 32'(last_rise - t0), 20);

    // 5: accept on the wrap edge, then drop en during PEND
    for (int i = 0; i < 20 && !(m_on && !m_pend_valid && (m_n + 1 - m_start == m_div2)); i++)
      applyStimulus(1, 0, 0);
    applyStimulus(1, 1, 10);
    checkOutput("t5_pending", cfg_ready_o, 0);
    upd_count = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(0, 0, 0);
      if (upd_o) upd_count++;
    end
    checkOutput("t5_upd_count", upd_count, 1);
    checkOutput("t5_div2", div2_act_o, 10);
    checkOutput("t5_off", running_o, 0);

    // 6: reset in the middle of a high phase
    for (int i = 0; i < 30 && !expClk(0); i++) applyStimulus(1, 0, 0);
    checkOutput("t6_high_before", clk_div_o, 1);
    rst_n = 1'b0;
    #1;
    checkResetValues("t6_rst");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
    for (int i = 0; i < 40; i++) applyStimulus(1, 0, 0);
    checkOutput("t6_gap", 32'(last_rise - prev_rise), 45);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) en = ~en;
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 24));
      applyStimulus(en, ($urandom_range(0, 3) == 0), d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
